// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader.
// Holds the loader state encoding and the word packing width.
package loader_pkg;

  typedef enum logic [1:0] {
    HEADER,
    DATA,
    DONE,
    ERR
  } state_e;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Little-endian byte-to-word assembler shared by header and data phases.
// word_valid fires while the last byte of a word is being accepted.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] sh_q, sh_d;

  always_comb begin
    idx_d = idx_q;
    sh_d  = sh_q;
    if (en_i) begin
      idx_d = idx_q + 2'd1;
      sh_d  = {byte_i, sh_q[31:8]};
    end
  end

  // Full word is visible combinationally on the cycle its last byte lands
  assign word_o       = sh_d;
  assign word_valid_o = en_i && (idx_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      sh_q  <= '0;
    end else begin
      idx_q <= idx_d;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Boot loader: byte stream -> length header + words -> instruction memory.
// Releases the core once all announced words are written.
module inst_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_run,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam logic [32:0] CAP = 33'd1 << ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   n_q, n_d, cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              run_q, run_d;
  logic              err_q, err_d;

  logic        pk_en;
  logic        pk_valid;
  logic [31:0] pk_word;

  assign in_ready = (state_q != DONE);
  assign pk_en    = in_valid && in_ready &&
                    (state_q == HEADER || state_q == DATA);

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .en_i         (pk_en),
    .byte_i       (in_data),
    .word_o       (pk_word),
    .word_valid_o (pk_valid)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    err_d   = err_q;
    // Core leaves reset one edge after DONE, once the last write retired
    run_d   = run_q | (state_q == DONE);
    unique case (state_q)
      HEADER: begin
        if (pk_valid) begin
          if (pk_word == '0) begin
            state_d = DONE;
          end else if ({1'b0, pk_word} > CAP) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d = DATA;
            n_d     = pk_word[ADDR_W:0];
          end
        end
      end
      DATA: begin
        if (pk_valid && cnt_q < n_q) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = pk_word;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == n_q) state_d = DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HEADER;
      n_q     <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign core_run  = run_q;
  assign err       = err_q;
  assign word_cnt  = cnt_q;

endmodule
